// File: rtl/oneshot_pkg.sv
// Shared definitions for the multi-channel button one-shot.
package oneshot_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_t;

  // True when a debounced transition in direction 'rise' is selected by mode m.
  function automatic logic edge_qualifies(input mode_t m, input logic rise);
    logic q;
    q = 1'b0;
    case (m)
      MODE_RISE: q = rise;
      MODE_FALL: q = ~rise;
      MODE_BOTH: q = 1'b1;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/oneshot_chan.sv
// One channel: synchroniser, debouncer, edge qualifier and pulse stretcher.
module oneshot_chan
  import oneshot_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 5,
  parameter int RETRIGGER       = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  btn_in,
  input  mode_t mode,
  output logic  pulse,
  output logic  level,
  output logic  pulse_nxt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int PW = $clog2(PULSE_LEN) + 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PULSE_LEN - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [DW-1:0]          dcnt;
  logic [PW-1:0]          pcnt;
  logic [PW-1:0]          pcnt_nxt;
  logic                   s;
  logic                   raw_ev;
  logic                   ev_q;

  assign s = sync[SYNC_STAGES-1];

  // A new level is accepted on the cycle the counter has seen it stable long enough.
  assign raw_ev = (s != level) && (dcnt == D_LAST);
  assign ev_q   = raw_ev && edge_qualifies(mode, s);

  // Synchroniser chain and debounce counter; level keeps tracking in every mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      level <= 1'b0;
      dcnt  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn_in};
      if (s == level) begin
        dcnt <= '0;
      end else if (dcnt == D_LAST) begin
        level <= s;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  // Stretcher next state; an ignored retrigger falls through to normal countdown.
  always_comb begin
    pulse_nxt = pulse;
    pcnt_nxt  = pcnt;
    if (ev_q && (!pulse || (RETRIGGER != 0))) begin
      pulse_nxt = 1'b1;
      pcnt_nxt  = P_LAST;
    end else if (pcnt != '0) begin
      pcnt_nxt = pcnt - PW'(1);
    end else begin
      pulse_nxt = 1'b0;
    end
  end

  // Stretcher state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse <= 1'b0;
      pcnt  <= '0;
    end else begin
      pulse <= pulse_nxt;
      pcnt  <= pcnt_nxt;
    end
  end

endmodule

// File: rtl/oneshot_multi.sv
// CHANNELS independent button one-shots with a shared edge mode and busy flag.
module oneshot_multi
  import oneshot_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 5,
  parameter int RETRIGGER       = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] level,
  output logic                busy
);

  logic [CHANNELS-1:0] pulse_nxt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    oneshot_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .PULSE_LEN      (PULSE_LEN),
      .RETRIGGER      (RETRIGGER)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in[i]),
      .mode     (mode_t'(mode)),
      .pulse    (pulse[i]),
      .level    (level[i]),
      .pulse_nxt(pulse_nxt[i])
    );
  end

  // busy is built from next-state pulses so it lands on the same edge as pulse.
  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= |pulse_nxt;
  end

endmodule

// File: doc/oneshot_multi.md
Name: oneshot_multi

Overview:
Parametrised successor to the single-button one-shot. It takes CHANNELS asynchronous button inputs and, per channel, synchronises, debounces, edge-qualifies (rising, falling, both or disabled) and stretches each qualifying event into a pulse of exactly PULSE_LEN clock cycles, with optional retrigger. It sits between the board push-buttons and the UART/control logic that consumes single-event strobes.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a new level (>=1); board top overrides for real buttons
PULSE_LEN, 5, output pulse width in clk cycles (>=1)
RETRIGGER, 1, 1 = an event during an active pulse reloads the length; 0 = event ignored while pulse active

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
btn_in  input  CHANNELS  raw asynchronous button levels
mode  input  2  global edge select: 00 rising, 01 falling, 10 both, 11 disabled
pulse  output  CHANNELS  stretched one-shot per channel
level  output  CHANNELS  debounced level per channel
busy  output  1  OR of pulse, registered alongside pulse

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. rst sampled high at an edge clears all sync flops, debounced levels, debounce counters, pulse counters, pulse, level and busy to 0. All outputs are 0 from the edge after rst is sampled high. rst high mid-pulse kills the pulse at that edge.
- Synchroniser: btn_in[i] passes through SYNC_STAGES flops. s[i] is the last stage.
- Debounce, per channel, counter dcnt of width $clog2(DEBOUNCE_CYCLES)+1:
  - If s[i]==level[i]: dcnt<=0.
  - Else if dcnt==DEBOUNCE_CYCLES-1: level[i]<=s[i], dcnt<=0, and a raw event is raised this cycle with direction s[i] (1 = rise, 0 = fall).
  - Else: dcnt<=dcnt+1.
  - A bounce shorter than DEBOUNCE_CYCLES stable cycles produces no level change.
- Qualification: the event is qualified by mode as sampled in the same cycle. Rise qualifies in 00 and 10; fall in 01 and 10; nothing in 11. Debounce and level keep tracking in every mode.
- Stretcher, per channel, counter pcnt of width $clog2(PULSE_LEN)+1:
  - Qualified event with pulse[i]==0: pulse[i]<=1, pcnt<=PULSE_LEN-1.
  - Qualified event with pulse[i]==1: if RETRIGGER, pcnt<=PULSE_LEN-1; otherwise ignored.
  - No event and pcnt>0: pcnt<=pcnt-1, pulse stays 1.
  - No event and pcnt==0: pulse[i]<=0.
  - Result: an isolated event gives exactly PULSE_LEN high cycles.
- Latency: btn_in changes before edge E0 and is held. level and pulse rise on edge E0+SYNC_STAGES+DEBOUNCE_CYCLES-1, which is edge E0+5 with defaults.
- Mode changes take effect on the next edge and never truncate or extend a pulse already running.
- Channels are fully independent. Simultaneous events on several channels pulse on identical cycles.
- Input high through reset release: level starts at 0, so a rise event occurs after the normal latency. This is intended and is suppressed only by mode 11.
- busy<=|next_pulse, so busy is cycle-aligned with pulse.

Decomposition:
- Package oneshot_pkg holds:
  - mode constants MODE_RISE=2'b00, MODE_FALL=2'b01, MODE_BOTH=2'b10, MODE_OFF=2'b11
  - a typedef for the 2-bit mode
- Sub-module oneshot_chan (sync + debounce + qualify + stretch for one channel, same parameters minus CHANNELS), instantiated CHANNELS times by a generate loop. The top holds only the generate loop and the busy reduction.

Test Plan:
1. Defaults, mode=00; btn_in[0] 0->1 held from edge E0 -> level[0] and pulse[0] rise at E0+5; pulse[0] high exactly 5 cycles; busy identical; other channels stay 0.
2. Bounce: btn_in[2] high for 3 cycles then low, mode=10 -> level[2], pulse[2] and busy stay 0 throughout.
3. mode=10; btn_in[1] rises, then falls 20 cycles later -> two 5-cycle pulses on pulse[1], 20 cycles apart; level[1] follows 1 then 0.
4. PULSE_LEN=8, mode=10; btn_in[0] rises, then falls 5 cycles later -> RETRIGGER=1: pulse[0] high for 13 continuous cycles; RETRIGGER=0: high for exactly 8 cycles.
5. btn_in[3] held high, rst asserted 2 cycles into a pulse -> pulse and level are 0 from that edge; after rst is released at edge R, pulse[3] rises at R+5 (or never, if mode=11).
6. btn_in[1] and btn_in[3] rise on the same cycle, mode=00, then repeat with mode=11 -> first run: identical 5-cycle pulses with busy aligned; second run: level updates but no pulse and busy stays 0.
